// File: rtl/ci_pkg.sv
// rtl/ci_pkg.sv - shared types and defaults for the custom-instruction initiator
package ci_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } ci_state_t;

  localparam int CI_DATA_W          = 32;
  localparam int CI_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/ci_timeout_ctr.sv
// rtl/ci_timeout_ctr.sv - WAIT-cycle watchdog counter; expired_o while count equals TIMEOUT_CYCLES
module ci_timeout_ctr
  import ci_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = CI_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Parks at LIMIT so a stalled slave cannot wrap the count back to zero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/ci_initiator.sv
// rtl/ci_initiator.sv - fabric-side master for the custom-instruction start/done handshake
// Optional response statistics counters: define CI_INITIATOR_STATS_EN.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int DATA_W         = CI_DATA_W,
  parameter int TIMEOUT_CYCLES = CI_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_dataa,
  input  logic [DATA_W-1:0] cmd_datab,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_error,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic              ci_reset,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result
`ifdef CI_INITIATOR_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [31:0]       stat_ops,
  output logic [15:0]       stat_timeouts
`endif
);

  ci_state_t         state_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_error_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              ci_clk_en_q;
  logic              ci_start_q;
  logic              ci_reset_q;
  logic [DATA_W-1:0] ci_dataa_q;
  logic [DATA_W-1:0] ci_datab_q;
  logic              expired;

  ci_timeout_ctr #(
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_ni   (reset_n),
    .clear_i  (state_q == ISSUE),
    .enable_i (state_q == WAIT),
    .expired_o(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_result_q <= '0;
      ci_clk_en_q  <= 1'b0;
      ci_start_q   <= 1'b0;
      ci_reset_q   <= 1'b0;
      ci_dataa_q   <= '0;
      ci_datab_q   <= '0;
    end else begin
      ci_start_q <= 1'b0;
      ci_reset_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            ci_dataa_q  <= cmd_dataa;
            ci_datab_q  <= cmd_datab;
            cmd_ready_q <= 1'b0;
            ci_start_q  <= 1'b1;
            ci_clk_en_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          // A done pulse coinciding with expiry is a genuine completion.
          if (ci_done) begin
            rsp_result_q <= ci_result;
            rsp_error_q  <= 1'b0;
            rsp_valid_q  <= 1'b1;
            ci_clk_en_q  <= 1'b0;
            state_q      <= HOLD;
          end else if (expired) begin
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            rsp_valid_q  <= 1'b1;
            ci_reset_q   <= 1'b1;
            ci_clk_en_q  <= 1'b0;
            state_q      <= HOLD;
          end
        end
        HOLD: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_result = rsp_result_q;
  assign ci_clk_en  = ci_clk_en_q;
  assign ci_start   = ci_start_q;
  assign ci_reset   = ci_reset_q;
  assign ci_dataa   = ci_dataa_q;
  assign ci_datab   = ci_datab_q;

`ifdef CI_INITIATOR_STATS_EN
  logic [31:0] stat_ops_q;
  logic [15:0] stat_timeouts_q;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // Clear outranks a same-cycle handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops_q      <= '0;
      stat_timeouts_q <= '0;
    end else if (stat_clear) begin
      stat_ops_q      <= '0;
      stat_timeouts_q <= '0;
    end else if (rsp_hs) begin
      stat_ops_q <= stat_ops_q + 32'd1;
      if (rsp_error_q && (stat_timeouts_q != 16'hFFFF)) begin
        stat_timeouts_q <= stat_timeouts_q + 16'd1;
      end
    end
  end

  assign stat_ops      = stat_ops_q;
  assign stat_timeouts = stat_timeouts_q;
`endif

endmodule

// File: tb/tb_ci_initiator.sv
// tb/tb_ci_initiator.sv - scoreboard bench for ci_initiator against a subtractive GCD slave
module tb_ci_initiator;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] cmd_dataa = '0;
  logic [DW-1:0] cmd_datab = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_result;
  logic          rsp_error;
  logic          ci_clk_en;
  logic          ci_start;
  logic          ci_reset;
  logic [DW-1:0] ci_dataa;
  logic [DW-1:0] ci_datab;
  logic          ci_done;
  logic [DW-1:0] ci_result;
`ifdef CI_INITIATOR_STATS_EN
  logic          stat_clear = 1'b0;
  logic [31:0]   stat_ops;
  logic [15:0]   stat_timeouts;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  always #5 clk = ~clk;

  ci_initiator #(
    .DATA_W        (DW),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dataa (cmd_dataa),
    .cmd_datab (cmd_datab),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_error (rsp_error),
    .ci_clk_en (ci_clk_en),
    .ci_start  (ci_start),
    .ci_reset  (ci_reset),
    .ci_dataa  (ci_dataa),
    .ci_datab  (ci_datab),
    .ci_done   (ci_done),
    .ci_result (ci_result)
`ifdef CI_INITIATOR_STATS_EN
    ,
    .stat_clear   (stat_clear),
    .stat_ops     (stat_ops),
    .stat_timeouts(stat_timeouts)
`endif
  );

  // Subtractive GCD slave: never finishes when one operand is zero.
  logic [DW-1:0] ga, gb, gres;
  logic          gbusy, gdone;
  assign ci_done   = gdone;
  assign ci_result = gres;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ga <= '0; gb <= '0; gres <= '0; gbusy <= 1'b0; gdone <= 1'b0;
    end else if (ci_reset) begin
      gbusy <= 1'b0; gdone <= 1'b0;
    end else begin
      gdone <= 1'b0;
      if (ci_clk_en) begin
        if (ci_start) begin
          ga <= ci_dataa; gb <= ci_datab; gbusy <= 1'b1;
        end else if (gbusy) begin
          if (ga == gb) begin
            gdone <= 1'b1; gres <= ga; gbusy <= 1'b0;
          end else if (ga > gb) begin
            ga <= ga - gb;
          end else begin
            gb <= gb - ga;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    logic [DW:0] e;
    #2;
    if (reset_n) begin
      if (ci_reset) chk("ci_reset_width", {63'd0, prev_rst}, 64'd0);
      prev_rst = ci_reset;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result", {32'd0, rsp_result}, {32'd0, e[DW-1:0]});
          chk("rsp_error", {63'd0, rsp_error}, {63'd0, e[DW]});
        end
      end
    end else begin
      prev_rst = 1'b0;
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input bit push, input logic [DW-1:0] er, input logic ee);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("cmd_accept_timeout", 64'd1, 64'd0);
    if (push) exp_q.push_back({ee, er});
    cmd_valid = 1'b1; cmd_dataa = a; cmd_datab = b;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Position 1 is the cycle right after acceptance.
  task automatic observe(input int limit, output int first_rsp, output int start_first,
                         output int start_cnt, output int rst_first, output int ready_bad);
    first_rsp = -1; start_first = -1; start_cnt = 0; rst_first = -1; ready_bad = 0;
    for (int k = 1; k <= limit; k++) begin
      if (ci_start) begin
        start_cnt++;
        if (start_first < 0) start_first = k;
      end
      if (ci_reset && rst_first < 0) rst_first = k;
      if (cmd_ready) ready_bad++;
      if (rsp_valid) begin
        first_rsp = k;
        break;
      end
      @(negedge clk);
    end
    if (first_rsp < 0) chk("rsp_wait_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, sf, sc, rf, rb, n;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
    chk("rst_ci_start", {63'd0, ci_start}, 64'd0);
    chk("rst_ci_reset", {63'd0, ci_reset}, 64'd0);
    chk("rst_ci_clk_en", {63'd0, ci_clk_en}, 64'd0);
    chk("rst_rsp_result", {32'd0, rsp_result}, 64'd0);
    chk("rst_ci_dataa", {32'd0, ci_dataa}, 64'd0);
    chk("rst_ci_datab", {32'd0, ci_datab}, 64'd0);
    reset_n = 1'b1;

    send(32'd12, 32'd8, 1'b1, 32'd4, 1'b0);
    chk("gcd12_dataa", {32'd0, ci_dataa}, 64'd12);
    chk("gcd12_datab", {32'd0, ci_datab}, 64'd8);
    chk("gcd12_clk_en", {63'd0, ci_clk_en}, 64'd1);
    observe(40, fr, sf, sc, rf, rb);
    chk("gcd12_rsp_latency", 64'(fr), 64'd6);
    chk("gcd12_start_pos", 64'(sf), 64'd1);
    chk("gcd12_start_cnt", 64'(sc), 64'd1);

    send(32'd7, 32'd7, 1'b1, 32'd7, 1'b0);
    observe(40, fr, sf, sc, rf, rb);
    chk("eq_rsp_latency", 64'(fr), 64'd4);
    chk("eq_cmd_ready_low", 64'(rb), 64'd0);
    @(negedge clk);
    chk("eq_dataa_kept", {32'd0, ci_dataa}, 64'd7);
    chk("eq_clk_en_off", {63'd0, ci_clk_en}, 64'd0);

    rsp_ready = 1'b0;
    send(32'd100, 32'd75, 1'b1, 32'd25, 1'b0);
    observe(60, fr, sf, sc, rf, rb);
    chk("bp_rsp_latency", 64'(fr), 64'd7);
    exp_q.push_back({1'b0, 32'd7});
    cmd_valid = 1'b1; cmd_dataa = 32'd21; cmd_datab = 32'd14;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid_held", {63'd0, rsp_valid}, 64'd1);
      chk("bp_rsp_result_stable", {32'd0, rsp_result}, 64'd25);
      chk("bp_cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_ready", {63'd0, cmd_ready}, 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_second_dataa", {32'd0, ci_dataa}, 64'd21);
    chk("bp_second_datab", {32'd0, ci_datab}, 64'd14);
    observe(60, fr, sf, sc, rf, rb);

    send(32'd0, 32'd5, 1'b1, 32'd0, 1'b1);
    observe(60, fr, sf, sc, rf, rb);
    chk("to_rsp_pos", 64'(fr), 64'd19);
    chk("to_ci_reset_pos", 64'(rf), 64'd19);
    send(32'd9, 32'd6, 1'b1, 32'd3, 1'b0);
    observe(40, fr, sf, sc, rf, rb);
    chk("after_to_latency", 64'(fr), 64'd6);

    send(32'd1000, 32'd1, 1'b0, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    chk("mid_in_wait", {63'd0, ci_clk_en}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mid_ci_clk_en", {63'd0, ci_clk_en}, 64'd0);
    chk("mid_ci_reset", {63'd0, ci_reset}, 64'd0);
    chk("mid_ci_dataa", {32'd0, ci_dataa}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(32'd18, 32'd12, 1'b1, 32'd6, 1'b0);
    observe(40, fr, sf, sc, rf, rb);
    chk("after_mid_latency", 64'(fr), 64'd6);

`ifdef CI_INITIATOR_STATS_EN
    @(negedge clk);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    send(32'd12, 32'd8, 1'b1, 32'd4, 1'b0);
    observe(40, fr, sf, sc, rf, rb);
    send(32'd7, 32'd7, 1'b1, 32'd7, 1'b0);
    observe(40, fr, sf, sc, rf, rb);
    send(32'd9, 32'd6, 1'b1, 32'd3, 1'b0);
    observe(40, fr, sf, sc, rf, rb);
    send(32'd0, 32'd5, 1'b1, 32'd0, 1'b1);
    observe(60, fr, sf, sc, rf, rb);
    @(negedge clk);
    chk("stat_ops", {32'd0, stat_ops}, 64'd4);
    chk("stat_timeouts", {48'd0, stat_timeouts}, 64'd1);
    stat_clear = 1'b1;
    @(negedge clk);
    stat_clear = 1'b0;
    chk("stat_ops_clr", {32'd0, stat_ops}, 64'd0);
    chk("stat_timeouts_clr", {48'd0, stat_timeouts}, 64'd0);
`endif

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ci_initiator.md
Name: ci_initiator

Overview:
- Master side of the Nios II custom-instruction handshake.
- Takes operand pairs from a valid/ready command port and issues them to a multi-cycle custom-instruction slave: one-cycle `ci_start`, then wait for the slave's one-cycle `ci_done`.
- Returns the captured result on a valid/ready response port.
- Lets fabric logic (DMA, test sequencer) drive CI accelerators such as the GCD unit without the CPU.
- A timeout watchdog recovers from slaves that never finish, e.g. GCD with a zero operand.

Parameters:
- DATA_W, 32, operand and result width.
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before abort; must be >= 2.
- CNT_W, 16, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_dataa  in  DATA_W  operand A.
- cmd_datab  in  DATA_W  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  DATA_W  slave result, or 0 on timeout.
- rsp_error  out  1  1 = timeout abort.
- ci_clk_en  out  1  slave clock enable.
- ci_start  out  1  slave start pulse.
- ci_reset  out  1  active-high slave reset pulse.
- ci_dataa  out  DATA_W  slave operand A.
- ci_datab  out  DATA_W  slave operand B.
- ci_done  in  1  slave completion pulse.
- ci_result  in  DATA_W  slave result.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - cmd_ready = 1.
  - rsp_valid, rsp_error, ci_start, ci_reset, ci_clk_en = 0.
  - rsp_result, ci_dataa, ci_datab = 0.
  - timeout counter = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch operands into ci_dataa/ci_datab, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ci_start = 1, ci_clk_en = 1.
  - ci_dataa/ci_datab stable.
  - Clear the counter, go to WAIT.
- WAIT:
  - ci_clk_en = 1, ci_start = 0, counter increments each cycle.
  - On ci_done = 1: capture ci_result into rsp_result, rsp_error = 0, rsp_valid = 1 next cycle, go to HOLD.
  - If the counter reaches TIMEOUT_CYCLES with ci_done = 0:
    - ci_reset = 1 for exactly one cycle.
    - rsp_result = 0, rsp_error = 1, rsp_valid = 1, go to HOLD.
  - If ci_done and expiry occur in the same cycle, ci_done wins: normal completion, no ci_reset.
- HOLD:
  - ci_clk_en = 0.
  - rsp_valid and rsp_result/rsp_error held stable until rsp_valid & rsp_ready, then go to IDLE.
  - cmd_ready = 0 in every state except IDLE.
- Throughput: at most one outstanding command; no pipelining.
- ci_done is ignored outside WAIT.
- ci_dataa/ci_datab keep their last value after completion.
- Mid-operation reset: reset_n low during WAIT forces IDLE immediately; ci_reset is not pulsed. The slave shares the system reset, so it is cleared too.
- Latency example, gcd(12,8) against the GCD slave:
  - Accept at cycle N, ci_start at N+1.
  - Slave iterates over cycles N+2..N+4, ci_done seen at N+5.
  - rsp_valid at N+6.

Optional Feature:
- Macro: CI_INITIATOR_STATS_EN.
- Defined: adds ports
  - stat_clear  in  1.
  - stat_ops  out  32: increments on every response handshake.
  - stat_timeouts  out  16: increments on every timeout response, saturating at 0xFFFF.
  - Both counters reset to 0 on reset_n low or on stat_clear = 1. If stat_clear and a handshake occur in the same cycle, the counter ends at 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package ci_pkg:
  - state enum ci_state_t {IDLE, ISSUE, WAIT, HOLD}.
  - localparam CI_DATA_W = 32.
  - default timeout constant.
- One sub-module, ci_timeout_ctr:
  - Inputs: clear, enable.
  - Output: expired, active when count == TIMEOUT_CYCLES.
  - Parameters: CNT_W, TIMEOUT_CYCLES.
- The FSM and datapath stay in ci_initiator.

Test Plan:
- Normal completion: cmd (12,8) to the GCD slave, rsp_ready = 1 → one-cycle ci_start at N+1, rsp_valid at N+6, rsp_result = 4, rsp_error = 0.
- Equal operands: cmd (7,7) → rsp_result = 7, rsp_error = 0; cmd_ready low from N+1 until the handshake completes.
- Backpressure: cmd (100,75) with rsp_ready = 0 for 10 cycles → rsp_valid held, rsp_result = 25 stable, cmd_ready = 0 throughout; the queued second cmd is accepted only after the handshake.
- Timeout: cmd (0,5), TIMEOUT_CYCLES = 16 → one ci_reset pulse after 16 WAIT cycles, rsp_error = 1, rsp_result = 0; a following cmd (9,6) returns 3.
- Reset mid-operation: reset_n low during WAIT of cmd (1000,1) → all outputs at reset values immediately, no rsp_valid; the next cmd (18,12) returns 6.
- Stats (CI_INITIATOR_STATS_EN): 3 normal commands + 1 timeout → stat_ops = 4, stat_timeouts = 1; stat_clear → both 0 next cycle.
